// File: rtl/hawk_axiwr_arb.sv
// Round-robin arbiter sharing one AXI write master (64B line writes) among NREQ requesters.
// Latency: ready 1 cycle after grant, done 1 cycle after B; backpressure: one write in flight, AW/W held until ready.
module hawk_axiwr_arb #(
  parameter int NREQ    = 3,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NREQ-1:0]       req_valid_i,
  input  logic [NREQ*64-1:0]    req_addr_i,
  input  logic [NREQ*512-1:0]   req_data_i,
  input  logic [NREQ*64-1:0]    req_strb_i,
  output logic [NREQ-1:0]       req_ready_o,
  output logic [NREQ-1:0]       req_done_o,
  output logic                  req_err_o,
  output logic [63:0]           awaddr_o,
  output logic                  awvalid_o,
  input  logic                  awready_i,
  output logic [511:0]          wdata_o,
  output logic [63:0]           wstrb_o,
  output logic                  wvalid_o,
  input  logic                  wready_i,
  input  logic [1:0]            bresp_i,
  input  logic                  bvalid_i,
  output logic                  bready_o,
  output logic                  busy_o,
  output logic [IDW-1:0]        gnt_id_o,
  output logic                  timeout_o,
  input  logic                  timeout_clr_i
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_B} state_t;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WD_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit WD_EN = (TIMEOUT != 0);
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  state_t          state, state_nxt;
  logic [IDW-1:0]  rr_ptr, sel_id;
  logic            sel_vld, grant, aw_hs, w_hs, b_hs;
  logic            aw_done, w_done;
  logic [CW-1:0]   wd_cnt;
  int              k;

  assign awvalid_o = (state == SEND) && !aw_done;
  assign wvalid_o  = (state == SEND) && !w_done;
  assign bready_o  = (state == WAIT_B);
  assign busy_o    = (state != IDLE);
  assign aw_hs     = awvalid_o && awready_i;
  assign w_hs      = wvalid_o && wready_i;
  assign b_hs      = bready_o && bvalid_i;
  // Holding off while the done pulse is out keeps done and the next ready apart.
  assign grant     = (state == IDLE) && sel_vld && (req_done_o == '0);

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    sel_vld = 1'b0;
    sel_id  = '0;
    k       = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = (int'(rr_ptr) + i) % NREQ;
      if (req_valid_i[k]) begin
        sel_vld = 1'b1;
        sel_id  = IDW'(k);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = SEND;
      SEND:    if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WAIT_B;
      WAIT_B:  if (bvalid_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      awaddr_o    <= '0;
      wdata_o     <= '0;
      wstrb_o     <= '0;
      gnt_id_o    <= '0;
      rr_ptr      <= '0;
      req_ready_o <= '0;
      req_done_o  <= '0;
      req_err_o   <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
    end else begin
      req_ready_o <= '0;
      req_done_o  <= '0;
      req_err_o   <= 1'b0;
      if (grant) begin
        awaddr_o    <= req_addr_i[{sel_id, 6'b0} +: 64];
        wdata_o     <= req_data_i[{sel_id, 9'b0} +: 512];
        wstrb_o     <= req_strb_i[{sel_id, 6'b0} +: 64];
        gnt_id_o    <= sel_id;
        req_ready_o <= ONE << sel_id;
        aw_done     <= 1'b0;
        w_done      <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if (b_hs) begin
        req_done_o <= ONE << gnt_id_o;
        req_err_o  <= (bresp_i != 2'b00);
        rr_ptr     <= (gnt_id_o == IDW'(NREQ - 1)) ? '0 : gnt_id_o + 1'b1;
      end
    end
  end

  // Watchdog only flags; the transaction always runs to its B response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_cnt    <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (grant)
        wd_cnt <= '0;
      else if (busy_o && wd_cnt != WD_MAX)
        wd_cnt <= wd_cnt + 1'b1;
      if (WD_EN && busy_o && wd_cnt == WD_LAST)
        timeout_o <= 1'b1;
      else if (timeout_clr_i)
        timeout_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hawk_axiwr_arb.sv
// Directed bench for hawk_axiwr_arb: single write, round-robin, channel skew, error, watchdog, reset.
module tb_hawk_axiwr_arb;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [2:0]    req_valid_i;
  logic [191:0]  req_addr_i;
  logic [1535:0] req_data_i;
  logic [191:0]  req_strb_i;
  logic [2:0]    req_ready_o, req_done_o;
  logic          req_err_o;
  logic [63:0]   awaddr_o;
  logic          awvalid_o, awready_i;
  logic [511:0]  wdata_o;
  logic [63:0]   wstrb_o;
  logic          wvalid_o, wready_i;
  logic [1:0]    bresp_i;
  logic          bvalid_i, bready_o, busy_o;
  logic [1:0]    gnt_id_o;
  logic          timeout_o, timeout_clr_i;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  hawk_axiwr_arb #(.NREQ(3), .IDW(2), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .req_strb_i(req_strb_i), .req_ready_o(req_ready_o), .req_done_o(req_done_o),
    .req_err_o(req_err_o), .awaddr_o(awaddr_o), .awvalid_o(awvalid_o),
    .awready_i(awready_i), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o),
    .wready_i(wready_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .busy_o(busy_o), .gnt_id_o(gnt_id_o), .timeout_o(timeout_o),
    .timeout_clr_i(timeout_clr_i)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input logic [2:0] exp, input string tag);
    int n = 0;
    while (req_ready_o == 3'b000 && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk(tag, req_ready_o, exp);
  endtask

  task automatic wait_done(input logic [2:0] exp, input logic err, input string tag);
    int n = 0;
    while (req_done_o == 3'b000 && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk({tag, "_done"}, req_done_o, exp);
    chk({tag, "_err"}, req_err_o, err);
  endtask

  initial begin
    int ev[$];
    int exp_ev[8];
    int t_rdy[4];
    int rdy_cnt, done_cnt, overlap, cyc, v;

    rst_i = 1'b1; req_valid_i = '0; req_addr_i = '0; req_data_i = '0; req_strb_i = '0;
    awready_i = 1'b0; wready_i = 1'b0; bresp_i = 2'b00; bvalid_i = 1'b0; timeout_clr_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_outs", {req_ready_o, req_done_o, req_err_o, awvalid_o, wvalid_o, bready_o,
                     busy_o, gnt_id_o, timeout_o}, '0);
    chk("rst_payload", {awaddr_o, wstrb_o}, '0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Single write from requester 1, other lanes hold decoy payloads.
    req_addr_i = {64'h2222, 64'h000000FFF6200040, 64'h1111};
    req_data_i[1023:512] = {64{8'hA5}};
    req_strb_i[127:64] = '1;
    awready_i = 1'b1; wready_i = 1'b1; bvalid_i = 1'b1;
    req_valid_i = 3'b010;
    wait_ready(3'b010, "single_ready");
    chk("single_vld", {awvalid_o, wvalid_o, bready_o}, 3'b110);
    chk("single_awaddr", awaddr_o, 64'h000000FFF6200040);
    chk("single_wdata", wdata_o, {64{8'hA5}});
    chk("single_wstrb", wstrb_o, {64{1'b1}});
    chk("single_gnt", gnt_id_o, 2'd1);
    req_valid_i = 3'b000;
    @(negedge clk_i);
    chk("single_waitb", {awvalid_o, wvalid_o, bready_o, req_done_o}, 6'b001000);
    wait_done(3'b010, 1'b0, "single");
    @(negedge clk_i);
    chk("single_idle", {busy_o, req_done_o, gnt_id_o}, 6'b000001);

    // Round-robin from reset with all requesters valid.
    rst_i = 1'b1;
    req_valid_i = 3'b111;
    @(negedge clk_i);
    rst_i = 1'b0;
    rdy_cnt = 0; done_cnt = 0; overlap = 0; cyc = 0;
    exp_ev = '{0, 10, 1, 11, 2, 12, 0, 10};
    while (done_cnt < 4 && cyc < 60) begin
      @(negedge clk_i);
      cyc++;
      if (req_ready_o != 3'b000 && req_done_o != 3'b000) overlap++;
      if (req_ready_o != 3'b000) begin
        ev.push_back($clog2(req_ready_o));
        if (rdy_cnt < 4) t_rdy[rdy_cnt] = cyc;
        rdy_cnt++;
        if (rdy_cnt == 4) req_valid_i = 3'b000;
      end
      if (req_done_o != 3'b000) begin
        ev.push_back(10 + $clog2(req_done_o));
        done_cnt++;
      end
    end
    chk("rr_events", ev.size(), 8);
    for (int i = 0; i < 8; i++) begin
      v = (i < ev.size()) ? ev[i] : -1;
      chk($sformatf("rr_ev%0d", i), v, exp_ev[i]);
    end
    chk("rr_overlap", overlap, 0);
    chk("rr_period", t_rdy[1] - t_rdy[0], 4);
    bvalid_i = 1'b0;

    // W channel lags: AW accepted at once, W ready only on the sixth SEND cycle.
    awready_i = 1'b1; wready_i = 1'b0;
    req_valid_i = 3'b100;
    wait_ready(3'b100, "wskew_ready");
    req_valid_i = 3'b000;
    chk("wskew_s1", {awvalid_o, wvalid_o, bready_o}, 3'b110);
    for (int i = 2; i <= 6; i++) begin
      @(negedge clk_i);
      chk($sformatf("wskew_s%0d", i), {awvalid_o, wvalid_o, bready_o}, 3'b010);
      if (i == 6) wready_i = 1'b1;
    end
    @(negedge clk_i);
    chk("wskew_b", {awvalid_o, wvalid_o, bready_o}, 3'b001);
    bvalid_i = 1'b1;
    wait_done(3'b100, 1'b0, "wskew");
    bvalid_i = 1'b0;

    // AW channel lags.
    awready_i = 1'b0; wready_i = 1'b1;
    req_valid_i = 3'b001;
    wait_ready(3'b001, "awskew_ready");
    req_valid_i = 3'b000;
    chk("awskew_s1", {awvalid_o, wvalid_o, bready_o}, 3'b110);
    for (int i = 2; i <= 6; i++) begin
      @(negedge clk_i);
      chk($sformatf("awskew_s%0d", i), {awvalid_o, wvalid_o, bready_o}, 3'b100);
      if (i == 6) awready_i = 1'b1;
    end
    @(negedge clk_i);
    chk("awskew_b", {awvalid_o, wvalid_o, bready_o}, 3'b001);
    bvalid_i = 1'b1;
    wait_done(3'b001, 1'b0, "awskew");
    bvalid_i = 1'b0;

    // Both handshakes on the same edge.
    awready_i = 1'b0; wready_i = 1'b0;
    req_valid_i = 3'b010;
    wait_ready(3'b010, "same_ready");
    req_valid_i = 3'b000;
    @(negedge clk_i);
    chk("same_hold", {awvalid_o, wvalid_o, bready_o}, 3'b110);
    awready_i = 1'b1; wready_i = 1'b1;
    @(negedge clk_i);
    chk("same_b", {awvalid_o, wvalid_o, bready_o}, 3'b001);
    bvalid_i = 1'b1;
    wait_done(3'b010, 1'b0, "same");

    // SLVERR response; pointer then moves past requester 2 to requester 0.
    bresp_i = 2'b10;
    req_valid_i = 3'b111;
    wait_ready(3'b100, "err_ready");
    chk("err_gnt", gnt_id_o, 2'd2);
    req_valid_i = 3'b011;
    wait_done(3'b100, 1'b1, "err");
    bresp_i = 2'b00;
    wait_ready(3'b001, "err_next_ready");
    req_valid_i = 3'b000;
    wait_done(3'b001, 1'b0, "err_next");
    bvalid_i = 1'b0;

    // Watchdog: B withheld for 20 cycles after the grant.
    req_valid_i = 3'b010;
    wait_ready(3'b010, "wd_ready");
    req_valid_i = 3'b000;
    chk("wd_c0", timeout_o, 1'b0);
    repeat (15) @(negedge clk_i);
    chk("wd_c15", timeout_o, 1'b0);
    @(negedge clk_i);
    chk("wd_c16", timeout_o, 1'b1);
    repeat (4) @(negedge clk_i);
    chk("wd_c20_busy", {busy_o, bready_o}, 2'b11);
    bvalid_i = 1'b1;
    wait_done(3'b010, 1'b0, "wd");
    bvalid_i = 1'b0;
    chk("wd_sticky", timeout_o, 1'b1);
    timeout_clr_i = 1'b1;
    @(negedge clk_i);
    timeout_clr_i = 1'b0;
    chk("wd_clr", timeout_o, 1'b0);

    // Reset while AW is pending.
    awready_i = 1'b0; wready_i = 1'b0;
    req_valid_i = 3'b001;
    wait_ready(3'b001, "mrst_ready");
    chk("mrst_aw", awvalid_o, 1'b1);
    rst_i = 1'b1;
    #1;
    chk("mrst_outs", {req_ready_o, req_done_o, req_err_o, awvalid_o, wvalid_o, bready_o,
                      busy_o, gnt_id_o, timeout_o}, '0);
    chk("mrst_payload", {awaddr_o, wstrb_o}, '0);
    req_valid_i = 3'b111;
    @(negedge clk_i);
    rst_i = 1'b0;
    wait_ready(3'b001, "mrst_regrant");
    req_valid_i = 3'b000;
    awready_i = 1'b1; wready_i = 1'b1; bvalid_i = 1'b1;
    wait_done(3'b001, 1'b0, "mrst_fin");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
